sram_bus_arbiter: RTL and testbench

- Shares one SRAM-like memory port between the instruction-fetch requester (inst_*) and the load/store requester (data_*).
- Sits between the Fetch/Mem pipeline stages and the memory bridge.
- Data requests win by default. A starvation counter forces an inst grant after MAX_STARVE consecutive data grants that each bypassed a pending inst request.
- Exactly one transaction is outstanding at a time.

---
 rtl/sram_bus_arbiter_pkg.sv | 23 ++
 rtl/sram_bus_arbiter_arb_grant.sv | 29 ++
 rtl/sram_bus_arbiter.sv | 148 ++++++++++++++
 tb/tb_sram_bus_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bus_arbiter_pkg.sv
// Shared types for the SRAM-like bus arbiter.
//   arb_state_t : arbiter FSM states (idle / address phase / response phase)
//   owner_t     : which requester owns the memory port
//   req_bus_w() : width of one requester's packed {wr, size, wstrb, addr, wdata}
package sram_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_t;

  function automatic int unsigned req_bus_w(input int unsigned addr_w,
                                            input int unsigned data_w);
    return 1 + 2 + data_w / 8 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/sram_bus_arbiter_arb_grant.sv
// Combinational grant decision used while the arbiter is idle.
//   inst_req : instruction-fetch request pending
//   data_req : load/store request pending
//   streak   : consecutive data grants that bypassed a pending inst request
//   grant    : selected owner (OWNER_INST when nothing is requested)
module arb_grant
  import sram_bus_arbiter_pkg::*;
#(
  parameter int unsigned MAX_STARVE = 4,
  parameter int unsigned STREAK_W   = 3
) (
  input  logic                inst_req,
  input  logic                data_req,
  input  logic [STREAK_W-1:0] streak,
  output owner_t              grant
);

  logic inst_starved;

  assign inst_starved = inst_req && (streak == STREAK_W'(MAX_STARVE));

  always_comb begin
    grant = OWNER_INST;
    if (data_req && !inst_starved) begin
      grant = OWNER_DATA;
    end
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch (inst_*) and
// load/store (data_*). Data wins by default; after MAX_STARVE data grants
// that bypassed a pending inst request, inst is forced. One transaction is
// outstanding at a time.
//   clk, rst                  : clock, synchronous active-high reset
//   inst_* / data_*           : requester side (req, wr, size, wstrb, addr,
//                               wdata in; addr_ok, data_ok, rdata out)
//   mem_*                     : memory side (req, wr, size, wstrb, addr,
//                               wdata out; addr_ok, data_ok, rdata in)
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int unsigned MAX_STARVE = 4,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic                inst_wr,
  input  logic [1:0]          inst_size,
  input  logic [DATA_W/8-1:0] inst_wstrb,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic [DATA_W-1:0]   inst_wdata,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [1:0]          mem_size,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned STREAK_W = $clog2(MAX_STARVE + 1);
  localparam int unsigned BUS_W    = req_bus_w(ADDR_W, DATA_W);

  arb_state_t          state_q, state_d;
  owner_t              owner_q, owner_d;
  owner_t              grant, sel;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [BUS_W-1:0]    inst_bus, data_bus, mem_bus;
  logic                sel_req, hs, rsp;

  assign inst_bus = {inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata};
  assign data_bus = {data_wr, data_size, data_wstrb, data_addr, data_wdata};
  assign {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata} = mem_bus;

  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

  arb_grant #(
    .MAX_STARVE(MAX_STARVE),
    .STREAK_W  (STREAK_W)
  ) u_arb_grant (
    .inst_req(inst_req),
    .data_req(data_req),
    .streak  (streak_q),
    .grant   (grant)
  );

  // Live grant only in IDLE; once an owner is latched the mux stays locked
  // until that transaction's response returns.
  always_comb begin
    sel     = (state_q == ARB_IDLE) ? grant : owner_q;
    sel_req = (sel == OWNER_DATA) ? data_req : inst_req;
    mem_bus = (sel == OWNER_DATA) ? data_bus : inst_bus;

    mem_req = 1'b0;
    if (!rst && (state_q != ARB_RESP)) begin
      mem_req = sel_req;
    end

    hs           = mem_req && mem_addr_ok;
    inst_addr_ok = hs && (sel == OWNER_INST);
    data_addr_ok = hs && (sel == OWNER_DATA);

    // Response only counts in RESP, so a late data_ok after reset is dropped.
    rsp          = !rst && (state_q == ARB_RESP) && mem_data_ok;
    inst_data_ok = rsp && (owner_q == OWNER_INST);
    data_data_ok = rsp && (owner_q == OWNER_DATA);
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    streak_d = streak_q;

    unique case (state_q)
      ARB_IDLE: begin
        if (hs) begin
          state_d = ARB_RESP;
          owner_d = sel;
        end else if (inst_req || data_req) begin
          state_d = ARB_REQ;
          owner_d = sel;
        end
      end
      ARB_REQ: begin
        if (hs) begin
          state_d = ARB_RESP;
        end
      end
      ARB_RESP: begin
        if (mem_data_ok) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    if (hs) begin
      if ((sel == OWNER_DATA) && inst_req) begin
        if (streak_q != STREAK_W'(MAX_STARVE)) begin
          streak_d = streak_q + STREAK_W'(1);
        end
      end else begin
        streak_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      owner_q  <= OWNER_INST;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
module tb_sram_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
  logic [1:0]  inst_size;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  sram_bus_arbiter #(.MAX_STARVE(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;
  typedef struct { logic owner; req_t r; int cyc; } grant_t;
  typedef struct { logic owner; logic [31:0] rdata; logic chk_rd; int cyc; } resp_t;

  req_t        iq[$];
  req_t        dq[$];
  grant_t      exp_g[$];
  resp_t       exp_r[$];
  logic [31:0] memv [logic [31:0]];
  logic        addr_ok_en = 1'b1;
  int          lat = 1;

  assign mem_addr_ok = addr_ok_en;

  function automatic req_t mk(input logic wr, input logic [1:0] size, input logic [3:0] wstrb,
                              input logic [31:0] addr, input logic [31:0] wdata);
    req_t r;
    r.wr = wr; r.size = size; r.wstrb = wstrb; r.addr = addr; r.wdata = wdata;
    return r;
  endfunction

  task automatic push_g(input logic owner, input req_t r, input int cyc);
    grant_t g;
    g.owner = owner; g.r = r; g.cyc = cyc;
    exp_g.push_back(g);
  endtask

  task automatic push_r(input logic owner, input logic [31:0] rdata, input logic chk_rd, input int cyc);
    resp_t e;
    e.owner = owner; e.rdata = rdata; e.chk_rd = chk_rd; e.cyc = cyc;
    exp_r.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((exp_g.size() + exp_r.size() + iq.size() + dq.size() != 0) && k < budget) begin
      step(1);
      k++;
    end
    if (k >= budget) chk("drain_timeout", 64'(exp_g.size() + exp_r.size()), 0);
  endtask

  // Requesters: hold req and fields until addr_ok, then present the next one.
  initial begin : inst_requester
    logic got;
    req_t r;
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_wstrb = 0; inst_addr = 0; inst_wdata = 0;
    forever begin
      @(negedge clk);
      got = inst_req && inst_addr_ok;
      @(posedge clk);
      #2;
      if (got) inst_req = 0;
      if (!inst_req && iq.size() > 0) begin
        r = iq.pop_front();
        inst_wr = r.wr; inst_size = r.size; inst_wstrb = r.wstrb;
        inst_addr = r.addr; inst_wdata = r.wdata; inst_req = 1;
      end
    end
  end

  initial begin : data_requester
    logic got;
    req_t r;
    data_req = 0; data_wr = 0; data_size = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
    forever begin
      @(negedge clk);
      got = data_req && data_addr_ok;
      @(posedge clk);
      #2;
      if (got) data_req = 0;
      if (!data_req && dq.size() > 0) begin
        r = dq.pop_front();
        data_wr = r.wr; data_size = r.size; data_wstrb = r.wstrb;
        data_addr = r.addr; data_wdata = r.wdata; data_req = 1;
      end
    end
  end

  // Memory: responds lat+1 cycles after the address handshake.
  initial begin : mem_model
    logic        pend;
    int          cnt;
    logic [31:0] a;
    pend = 0; cnt = 0; a = 0;
    mem_data_ok = 0;
    mem_rdata   = 0;
    forever begin
      @(negedge clk);
      if (mem_req && mem_addr_ok) begin
        pend = 1; cnt = lat; a = mem_addr;
      end
      @(posedge clk);
      #1;
      mem_data_ok = 0;
      if (pend) begin
        if (cnt == 0) begin
          mem_data_ok = 1;
          mem_rdata   = memv.exists(a) ? memv[a] : 32'h0;
          pend        = 0;
        end else begin
          cnt--;
        end
      end
    end
  end

  initial begin : monitor
    grant_t g;
    resp_t  e;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_quiet", {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 0);
      end else begin
        if (mem_req && mem_addr_ok) begin
          if (exp_g.size() == 0) begin
            chk("unexpected_grant", {inst_addr_ok, data_addr_ok}, 0);
          end else begin
            g = exp_g.pop_front();
            chk("grant_data_ok_line", data_addr_ok, g.owner);
            chk("grant_inst_ok_line", inst_addr_ok, !g.owner);
            chk("grant_cycle", cyc_cnt, g.cyc);
            chk("mem_addr", mem_addr, g.r.addr);
            chk("mem_wr", mem_wr, g.r.wr);
            chk("mem_size", mem_size, g.r.size);
            chk("mem_wstrb", mem_wstrb, g.r.wstrb);
            chk("mem_wdata", mem_wdata, g.r.wdata);
          end
        end else if (inst_addr_ok || data_addr_ok) begin
          chk("stray_addr_ok", {inst_addr_ok, data_addr_ok}, 0);
        end
        if (inst_data_ok || data_data_ok) begin
          if (exp_r.size() == 0) begin
            chk("unexpected_data_ok", {inst_data_ok, data_data_ok}, 0);
          end else begin
            e = exp_r.pop_front();
            chk("resp_owner", {inst_data_ok, data_data_ok}, e.owner ? 2'b01 : 2'b10);
            chk("resp_cycle", cyc_cnt, e.cyc);
            if (e.chk_rd) begin
              chk("inst_rdata", inst_rdata, e.rdata);
              chk("data_rdata", data_rdata, e.rdata);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    req_t r, ri, rd, dv[8], iv[2];
    int   t0, di, ii;
    logic o;

    // Inst only, request raised while in reset.
    step(2);
    r = mk(0, 2, 4'h0, 32'h1c00_0000, 0);
    memv[r.addr] = 32'h0280_0000;
    iq.push_back(r);
    step(2);
    rst = 0;
    t0  = cyc_cnt;
    push_g(0, r, t0);
    push_r(0, 32'h0280_0000, 1, t0 + 2);
    wait_idle(50);

    // Simultaneous: data first, inst one bubble after data's response.
    t0 = cyc_cnt;
    rd = mk(0, 0, 4'h0, 32'h8000_0010, 0);
    ri = mk(0, 2, 4'h0, 32'h1c00_0004, 0);
    memv[rd.addr] = 32'h1111_2222;
    memv[ri.addr] = 32'h3333_4444;
    dq.push_back(rd);
    iq.push_back(ri);
    push_g(1, rd, t0);
    push_r(1, 32'h1111_2222, 1, t0 + 2);
    push_g(0, ri, t0 + 3);
    push_r(0, 32'h3333_4444, 1, t0 + 5);
    wait_idle(50);

    // Grant lock: inst stalled in REQ, data arrives and must wait.
    addr_ok_en = 0;
    t0 = cyc_cnt;
    ri = mk(0, 2, 4'h0, 32'h1c00_0008, 0);
    rd = mk(0, 1, 4'h0, 32'h8000_0020, 0);
    memv[ri.addr] = 32'h5555_6666;
    memv[rd.addr] = 32'h7777_8888;
    iq.push_back(ri);
    push_g(0, ri, t0 + 3);
    push_r(0, 32'h5555_6666, 1, t0 + 5);
    push_g(1, rd, t0 + 6);
    push_r(1, 32'h7777_8888, 1, t0 + 8);
    @(negedge clk);
    chk("lock_c0_mem_req", mem_req, 1);
    chk("lock_c0_mem_addr", mem_addr, ri.addr);
    step(1);
    dq.push_back(rd);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      chk("lock_mem_req", mem_req, 1);
      chk("lock_mem_addr", mem_addr, ri.addr);
      chk("lock_data_addr_ok", data_addr_ok, 0);
      step(1);
    end
    addr_ok_en = 1;
    wait_idle(50);

    // Starvation: 8 data + 2 inst queued together -> D D D D I D D D D I.
    t0 = cyc_cnt;
    for (int k = 0; k < 8; k++) begin
      dv[k] = mk(0, 0, 4'h0, 32'h8000_0100 + 32'(4 * k), 0);
      memv[dv[k].addr] = 32'hA000_0000 + 32'(k);
      dq.push_back(dv[k]);
    end
    for (int k = 0; k < 2; k++) begin
      iv[k] = mk(0, 2, 4'h0, 32'h1c00_0100 + 32'(4 * k), 0);
      memv[iv[k].addr] = 32'hB000_0000 + 32'(k);
      iq.push_back(iv[k]);
    end
    di = 0;
    ii = 0;
    for (int k = 0; k < 10; k++) begin
      o = (k == 4 || k == 9) ? 1'b0 : 1'b1;
      if (o) begin
        push_g(1, dv[di], t0 + 3 * k);
        push_r(1, 32'hA000_0000 + 32'(di), 1, t0 + 3 * k + 2);
        di++;
      end else begin
        push_g(0, iv[ii], t0 + 3 * k);
        push_r(0, 32'hB000_0000 + 32'(ii), 1, t0 + 3 * k + 2);
        ii++;
      end
    end
    wait_idle(200);

    // Reset during RESP: late mem_data_ok must not reach the requester.
    lat = 4;
    t0  = cyc_cnt;
    rd  = mk(0, 2, 4'h0, 32'h8000_0200, 0);
    memv[rd.addr] = 32'h1234_5678;
    dq.push_back(rd);
    push_g(1, rd, t0);
    step(1);
    rst = 1;
    step(1);
    rst = 0;
    step(3);
    @(negedge clk);
    chk("late_data_ok_dropped", {inst_data_ok, data_data_ok}, 0);
    step(2);

    // Write after reset: issues immediately from IDLE.
    lat = 1;
    t0  = cyc_cnt;
    rd  = mk(1, 2, 4'hF, 32'h8000_0300, 32'hDEAD_BEEF);
    dq.push_back(rd);
    push_g(1, rd, t0);
    push_r(1, 32'h0, 0, t0 + 2);
    wait_idle(50);

    step(3);
    chk("queues_drained", 64'(exp_g.size() + exp_r.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
